// File: rtl/sbrb_pkg.sv
// Shared definitions for the SbRb latch arbiter: FSM state encodings, opcodes
// and a small elaboration-time helper.
package sbrb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sbrb_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit at or after rr_ptr,
// wrapping modulo N_REQ.
module sbrb_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    int j;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(rr_ptr) + i) % N_REQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sbrb_latch_arbiter.sv
// Round-robin arbiter sharing one active-low SbRb latch between N_REQ requesters.
// Define SBRB_READBACK_EN to compare Q_fb with the granted op and flag mismatches on err.
module sbrb_latch_arbiter
    import sbrb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] ack,
    output logic             Sb,
    output logic             Rb,
    input  logic             Q_fb,
    output logic             busy,
    output logic             err
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_MAX = max_int(PULSE_CYC, GAP_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (N_REQ < 2 || PULSE_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
        $error("sbrb_latch_arbiter: N_REQ must be >= 2, PULSE_CYC and GAP_CYC >= 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             op_q, op_d;
    logic             sb_d, rb_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    sbrb_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_q),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            op_q    <= OP_RST;
            Sb      <= 1'b1;
            Rb      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            Sb      <= sb_d;
            Rb      <= rb_d;
        end
    end

    // Sb/Rb are derived from a single registered op bit, so only one can ever be driven low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        op_d    = op_q;
        sb_d    = 1'b1;
        rb_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = PULSE;
                    idx_d   = pick_idx;
                    op_d    = |(op & pick_onehot);
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    sb_d    = (op_d != OP_SET);
                    rb_d    = (op_d != OP_RST);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    sb_d  = (op_q != OP_SET);
                    rb_d  = (op_q != OP_RST);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rr_d    = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == GAP && cnt_q == '0) ack[idx_q] = 1'b1;
    end

    assign busy = (state_q != IDLE);

`ifdef SBRB_READBACK_EN
    // By the first GAP cycle the latch has settled to the granted op's value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_q == GAP && cnt_q == CNT_W'(GAP_CYC - 1) && Q_fb != op_q) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = Q_fb;
    assign err         = 1'b0;
`endif

endmodule
